// File: rtl/skid_reg_param.sv
// skid_reg_param
// Two-entry valid/ready pipeline register (skid buffer). The producer side
// handshake (in_valid/in_ready) and the consumer side handshake
// (out_valid/out_ready) share no combinational path: every output is decoded
// from flops only. One transfer per cycle is sustained while out_ready is high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of all held entries
//   in_data    producer payload (WIDTH bits)
//   in_valid   producer offers in_data this cycle
//   in_ready   block can accept this cycle (decoded from state register)
//   out_data   payload presented to consumer (main register)
//   out_valid  out_data is valid (decoded from state register)
//   out_ready  consumer accepts this cycle
//   occupancy  number of entries held, 0..2
module skid_reg_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Handshake outputs depend on the state register only; out_ready never
  // reaches in_ready, which is what breaks the backward combinational path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: every signal gets a default before the case so that no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Anything accepted this cycle is dropped; the consumer's take stands.
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the consumer can move things.
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_next     = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the payload registers are reset because out_data must read 0 after
  // reset; a pure datapath register would normally be left without reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_skid_reg_param.sv
// Self-checking bench for skid_reg_param. A queue scoreboard receives every
// accepted word and is compared against the DUT outputs every cycle; each
// scenario task adds its own direct checks.
module tb_skid_reg_param;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       occupancy;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [WIDTH-1:0] sb_q[$];

  skid_reg_param #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: at the falling edge inputs and outputs are both stable.
  // Compare the DUT against the queue, then apply the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      int  n;
      logic ofire;
      logic ifire;
      n = sb_q.size();
      checks++;
      if (out_valid !== (n > 0)) begin
        errors++;
        $display("FAIL sb_out_valid: got %b expected %b", out_valid, (n > 0));
      end
      checks++;
      if (occupancy !== 2'(n)) begin
        errors++;
        $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, n);
      end
      checks++;
      if (in_ready !== (n < 2)) begin
        errors++;
        $display("FAIL sb_in_ready: got %b expected %b", in_ready, (n < 2));
      end
      if (n > 0) begin
        checks++;
        if (out_data !== sb_q[0]) begin
          errors++;
          $display("FAIL sb_out_data: got %h expected %h", out_data, sb_q[0]);
        end
      end
      ofire = (n > 0) && (out_ready === 1'b1);
      ifire = (in_valid === 1'b1) && (n < 2);
      if (ofire) begin
        void'(sb_q.pop_front());
        pops++;
      end
      if (flush === 1'b1) begin
        sb_q.delete();
      end else if (ifire) begin
        sb_q.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = 'x;
    flush     = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    out_ready = 1'b1;
    idle_inputs();
    while (sb_q.size() > 0 && c < max_cycles) begin
      tick();
      c++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left expected 0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%b occ=%0d d=%h expected 0 1 0 0",
               out_valid, in_ready, occupancy, out_data);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data   = 32'h22;
    tick();
    idle_inputs();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_full: occupancy got %0d expected 2", occupancy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got v=%b r=%b occ=%0d d=%h expected 0 1 0 0",
               out_valid, in_ready, occupancy, out_data);
    end
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: out_valid got %b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_streaming();
    int p0;
    p0 = pops;
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      tick();
      checks++;
      if (out_data !== WIDTH'(i) || out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got d=%h v=%b occ=%0d r=%b expected %h 1 1 1",
                 i, out_data, out_valid, occupancy, in_ready, WIDTH'(i));
      end
    end
    drain(10);
    checks++;
    if (pops - p0 != 100) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 100", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data   = 32'hB;
    tick();
    in_data   = 32'hC;
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d r=%b d=%h expected 2 0 0000000a",
               occupancy, in_ready, out_data);
    end
    tick();
    tick();
    checks++;
    if (occupancy !== 2'd2 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_hold: got occ=%0d d=%h expected 2 0000000a", occupancy, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 32'hB || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_second: got d=%h occ=%0d expected 0000000b 1", out_data, occupancy);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_data !== 32'hC || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_third: got d=%h occ=%0d expected 0000000c 1", out_data, occupancy);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty: occupancy got %0d expected 0", occupancy);
    end
  endtask

  task automatic test_alternating();
    int p0;
    int sent;
    int c;
    p0   = pops;
    sent = 0;
    c    = 0;
    while (sent < 16 && c < 200) begin
      out_ready = (c % 2 == 0);
      in_valid  = 1'b1;
      in_data   = WIDTH'(32'h10 + sent);
      if (in_ready === 1'b1) sent++;
      tick();
      c++;
      checks++;
      if (occupancy > 2'd2) begin
        errors++;
        $display("FAIL alt_occupancy: got %0d expected <= 2", occupancy);
      end
    end
    checks++;
    if (sent != 16) begin
      errors++;
      $display("FAIL alt_accept_timeout: sent %0d expected 16", sent);
    end
    drain(20);
    checks++;
    if (pops - p0 != 16) begin
      errors++;
      $display("FAIL alt_count: got %0d expected 16", pops - p0);
    end
  endtask

  task automatic test_flush();
    // Flush while full, offering 0x7 in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    in_data   = 32'h6;
    tick();
    in_data   = 32'h7;
    flush     = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_full: got v=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
    // Flush while busy so 0x7 is genuinely handshaken and must be dropped.
    in_valid = 1'b1;
    in_data  = 32'h8;
    tick();
    in_data  = 32'h7;
    flush    = 1'b1;
    tick();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL flush_busy_%0d: got v=%b occ=%0d d=%h expected 0 0",
                 i, out_valid, occupancy, out_data);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_data   = 32'h66;
    out_ready = 1'b1;
    checks++;
    if (out_data !== 32'h55 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL simul_before: got d=%h occ=%0d expected 00000055 1", out_data, occupancy);
    end
    tick();
    idle_inputs();
    checks++;
    if (out_data !== 32'h66 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_after: got d=%h occ=%0d v=%b expected 00000066 1 1",
               out_data, occupancy, out_valid);
    end
    drain(10);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_streaming();
    test_backpressure();
    test_alternating();
    test_flush();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
